// File: rtl/cvxif_offload_pkg.sv
// ============================================================================
// Module : cvxif_offload_pkg
// Brief  : Shared types for the CV-X-IF compressed-instruction offload stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cvxif_offload_pkg;

    localparam int unsigned MaxSlots = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFLOAD = 2'd1,
        PRESENT = 2'd2
    } offload_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic        is_compressed;
        logic        is_illegal;
    } slot_t;

endpackage

`default_nettype wire

// File: rtl/cvxif_compressed_offload_seq_lzc.sv
// ============================================================================
// Module : lzc
// Brief  : Leading/trailing zero counter (MODE=0 counts trailing zeros).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o = '0;
        if (MODE) begin
            // Last hit wins, so scanning upward leaves the highest set bit.
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
            end
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

`default_nettype wire

// File: rtl/cvxif_compressed_offload_seq.sv
// ============================================================================
// Module : cvxif_compressed_offload_seq
// Brief  : Captures a fetch bundle, offloads illegal compressed slots one by
//          one over CV-X-IF and presents the patched bundle downstream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cvxif_compressed_offload_seq
    import cvxif_offload_pkg::*;
#(
    parameter int unsigned NrSlots     = 2,
    parameter int unsigned HartIdWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [HartIdWidth-1:0] hart_id_i,
    input  logic                   bundle_valid_i,
    input  logic [NrSlots-1:0]     is_compressed_i,
    input  logic [NrSlots-1:0]     is_illegal_i,
    input  logic [NrSlots*32-1:0]  instruction_i,
    input  logic                   stall_i,
    output logic                   bundle_valid_o,
    output logic [NrSlots-1:0]     is_compressed_o,
    output logic [NrSlots-1:0]     is_illegal_o,
    output logic [NrSlots*32-1:0]  instruction_o,
    output logic                   stall_o,
    output logic                   compressed_valid_o,
    input  logic                   compressed_ready_i,
    output logic [15:0]            compressed_instr_o,
    output logic [HartIdWidth-1:0] compressed_hartid_o,
    input  logic                   compressed_accept_i,
    input  logic [31:0]            compressed_resp_instr_i
);

    localparam int unsigned IdxWidth = (NrSlots > 1) ? $clog2(NrSlots) : 1;

    offload_state_e       state_q, state_d;
    slot_t                slots_q [NrSlots];
    slot_t                slots_d [NrSlots];
    logic [NrSlots-1:0]   pending_q, pending_d;
    logic [NrSlots-1:0]   cand;
    logic [IdxWidth-1:0]  sel_idx;
    logic                 pend_empty;

    assign cand                = {NrSlots{bundle_valid_i}} & is_illegal_i & is_compressed_i;
    assign compressed_hartid_o = hart_id_i;

    lzc #(
        .WIDTH     (NrSlots),
        .MODE      (1'b0),
        .CNT_WIDTH (IdxWidth)
    ) i_lzc (
        .in_i    (pending_q),
        .cnt_o   (sel_idx),
        .empty_o (pend_empty)
    );

    always_comb begin
        state_d            = state_q;
        pending_d          = pending_q;
        slots_d            = slots_q;
        bundle_valid_o     = bundle_valid_i;
        stall_o            = stall_i;
        compressed_valid_o = 1'b0;
        compressed_instr_o = '0;
        is_compressed_o    = is_compressed_i;
        is_illegal_o       = is_illegal_i;
        instruction_o      = instruction_i;

        // Outside IDLE the captured bundle is what downstream sees.
        if (state_q != IDLE) begin
            for (int i = 0; i < int'(NrSlots); i++) begin
                is_compressed_o[i]     = slots_q[i].is_compressed;
                is_illegal_o[i]        = slots_q[i].is_illegal;
                instruction_o[32*i+:32] = slots_q[i].instr;
            end
        end

        unique case (state_q)
            IDLE: begin
                if ((|cand) && !flush_i) begin
                    bundle_valid_o = 1'b0;
                    stall_o        = 1'b1;
                    pending_d      = cand;
                    state_d        = OFFLOAD;
                    for (int i = 0; i < int'(NrSlots); i++) begin
                        slots_d[i] = '{instr:         instruction_i[32*i+:32],
                                       is_compressed: is_compressed_i[i],
                                       is_illegal:    is_illegal_i[i]};
                    end
                end
            end
            OFFLOAD: begin
                bundle_valid_o     = 1'b0;
                stall_o            = 1'b1;
                compressed_valid_o = ~pend_empty;
                for (int i = 0; i < int'(NrSlots); i++) begin
                    if (sel_idx == IdxWidth'(i)) compressed_instr_o = slots_q[i].instr[15:0];
                end
                if (compressed_valid_o && compressed_ready_i) begin
                    for (int i = 0; i < int'(NrSlots); i++) begin
                        if (sel_idx == IdxWidth'(i)) begin
                            pending_d[i] = 1'b0;
                            if (compressed_accept_i) begin
                                slots_d[i] = '{instr:         compressed_resp_instr_i,
                                               is_compressed: 1'b0,
                                               is_illegal:    1'b0};
                            end
                        end
                    end
                end
                if (pending_d == '0) state_d = PRESENT;
            end
            PRESENT: begin
                bundle_valid_o = 1'b1;
                stall_o        = stall_i;
                if (!stall_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over capture and over any handshake in the same cycle.
        if (flush_i) begin
            state_d   = IDLE;
            pending_d = '0;
            slots_d   = slots_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= '0;
            for (int i = 0; i < int'(NrSlots); i++) slots_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            for (int i = 0; i < int'(NrSlots); i++) slots_q[i] <= slots_d[i];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cvxif_compressed_offload_seq.sv
// ============================================================================
// Module : tb_cvxif_compressed_offload_seq
// Brief  : Directed self-checking bench for the compressed offload stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cvxif_compressed_offload_seq;

    localparam int unsigned N = 4;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           flush_i;
    logic [31:0]    hart_id_i;
    logic           bundle_valid_i;
    logic [N-1:0]   is_compressed_i, is_illegal_i;
    logic [N*32-1:0] instruction_i;
    logic           stall_i;
    logic           bundle_valid_o;
    logic [N-1:0]   is_compressed_o, is_illegal_o;
    logic [N*32-1:0] instruction_o;
    logic           stall_o;
    logic           compressed_valid_o;
    logic           compressed_ready_i;
    logic [15:0]    compressed_instr_o;
    logic [31:0]    compressed_hartid_o;
    logic           compressed_accept_i;
    logic [31:0]    compressed_resp_instr_i;

    always #5 clk_i = ~clk_i;

    cvxif_compressed_offload_seq #(.NrSlots(N), .HartIdWidth(32)) dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .flush_i                 (flush_i),
        .hart_id_i               (hart_id_i),
        .bundle_valid_i          (bundle_valid_i),
        .is_compressed_i         (is_compressed_i),
        .is_illegal_i            (is_illegal_i),
        .instruction_i           (instruction_i),
        .stall_i                 (stall_i),
        .bundle_valid_o          (bundle_valid_o),
        .is_compressed_o         (is_compressed_o),
        .is_illegal_o            (is_illegal_o),
        .instruction_o           (instruction_o),
        .stall_o                 (stall_o),
        .compressed_valid_o      (compressed_valid_o),
        .compressed_ready_i      (compressed_ready_i),
        .compressed_instr_o      (compressed_instr_o),
        .compressed_hartid_o     (compressed_hartid_o),
        .compressed_accept_i     (compressed_accept_i),
        .compressed_resp_instr_i (compressed_resp_instr_i)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        name;
        logic         bv;
        logic [3:0]   comp;
        logic [3:0]   ill;
        logic [127:0] instr;
        logic         stall;
        logic         exp_bv;
        logic         exp_stall;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic capture(input logic [3:0] comp, input logic [3:0] ill, input logic [127:0] instr);
        bundle_valid_i  = 1'b1;
        is_compressed_i = comp;
        is_illegal_i    = ill;
        instruction_i   = instr;
    endtask

    // One candidate in slot0; accept selects the patched or the rejected outcome.
    task automatic single(input logic acc);
        logic [127:0] exp_instr;
        capture(4'b0001, 4'b0001, {32'h11111111, 32'h22222222, 32'h33333333, 32'h00009002});
        stall_i                 = 1'b0;
        compressed_ready_i      = 1'b1;
        compressed_accept_i     = acc;
        compressed_resp_instr_i = 32'h00100073;
        #1;
        chk("single_c0_stall", stall_o, 1'b1);
        chk("single_c0_bv", bundle_valid_o, 1'b0);
        tick();
        bundle_valid_i = 1'b0;
        #1;
        chk("single_c1_cvalid", compressed_valid_o, 1'b1);
        chk("single_c1_cinstr", compressed_instr_o, 16'h9002);
        chk("single_c1_stall", stall_o, 1'b1);
        chk("single_c1_hartid", compressed_hartid_o, 32'h000000A5);
        tick();
        exp_instr = {32'h11111111, 32'h22222222, 32'h33333333, acc ? 32'h00100073 : 32'h00009002};
        chk("single_c2_bv", bundle_valid_o, 1'b1);
        chk("single_c2_instr", instruction_o, exp_instr);
        chk("single_c2_comp", is_compressed_o, acc ? 4'b0000 : 4'b0001);
        chk("single_c2_ill", is_illegal_o, acc ? 4'b0000 : 4'b0001);
        chk("single_c2_cvalid", compressed_valid_o, 1'b0);
        tick();
        chk("single_c3_idle_bv", bundle_valid_o, 1'b0);
        chk("single_c3_idle_stall", stall_o, 1'b0);
    endtask

    initial begin
        vecs[0] = '{"pt_plain", 1'b1, 4'b0000, 4'b0000,
                    {32'h0, 32'h0, 32'h00A00093, 32'h00000013}, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{"pt_stall", 1'b1, 4'b0011, 4'b0000,
                    {32'h12345678, 32'h9ABCDEF0, 32'h00004501, 32'h00008082}, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{"pt_ill32", 1'b1, 4'b0000, 4'b1111,
                    {32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0}, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"pt_noval", 1'b0, 4'b1111, 4'b1111,
                    {32'h00009002, 32'h00009002, 32'h00009002, 32'h00009002}, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"pt_disj", 1'b1, 4'b1010, 4'b0101,
                    {32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0}, 1'b1, 1'b1, 1'b1};

        rst_ni                  = 1'b0;
        flush_i                 = 1'b0;
        hart_id_i               = 32'h000000A5;
        bundle_valid_i          = 1'b0;
        is_compressed_i         = 4'b0110;
        is_illegal_i            = 4'b0011;
        instruction_i           = {32'hCAFEF00D, 32'h0BADBEEF, 32'h00009002, 32'h00004501};
        stall_i                 = 1'b1;
        compressed_ready_i      = 1'b0;
        compressed_accept_i     = 1'b0;
        compressed_resp_instr_i = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_bv", bundle_valid_o, 1'b0);
        chk("rst_cvalid", compressed_valid_o, 1'b0);
        chk("rst_stall", stall_o, 1'b1);
        chk("rst_instr", instruction_o, {32'hCAFEF00D, 32'h0BADBEEF, 32'h00009002, 32'h00004501});
        chk("rst_comp", is_compressed_o, 4'b0110);
        chk("rst_ill", is_illegal_o, 4'b0011);
        rst_ni  = 1'b1;
        stall_i = 1'b0;
        tick();

        // Combinational pass-through vectors
        for (int v = 0; v < 5; v++) begin
            bundle_valid_i  = vecs[v].bv;
            is_compressed_i = vecs[v].comp;
            is_illegal_i    = vecs[v].ill;
            instruction_i   = vecs[v].instr;
            stall_i         = vecs[v].stall;
            #1;
            chk({vecs[v].name, "_bv"}, bundle_valid_o, vecs[v].exp_bv);
            chk({vecs[v].name, "_stall"}, stall_o, vecs[v].exp_stall);
            chk({vecs[v].name, "_cvalid"}, compressed_valid_o, 1'b0);
            chk({vecs[v].name, "_instr"}, instruction_o, vecs[v].instr);
            chk({vecs[v].name, "_comp"}, is_compressed_o, vecs[v].comp);
            chk({vecs[v].name, "_ill"}, is_illegal_o, vecs[v].ill);
            tick();
        end
        bundle_valid_i = 1'b0;
        stall_i        = 1'b0;
        tick();

        // Single accepted offload, then single rejected offload
        single(1'b1);
        single(1'b0);

        // Slots 1 and 3 offloaded with back-pressure; slot1 accepted, slot3 rejected
        capture(4'b1010, 4'b1110, {32'h00008082, 32'hFFFFFFFF, 32'h00004501, 32'h00000013});
        compressed_ready_i      = 1'b0;
        compressed_accept_i     = 1'b1;
        compressed_resp_instr_i = 32'hDEADBEEF;
        #1;
        chk("bp_c0_stall", stall_o, 1'b1);
        tick();
        bundle_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            compressed_ready_i      = (c == 3);
            compressed_accept_i     = 1'b1;
            compressed_resp_instr_i = (c == 3) ? 32'h00000513 : 32'hDEADBEEF;
            #1;
            chk("bp_s1_cvalid", compressed_valid_o, 1'b1);
            chk("bp_s1_cinstr", compressed_instr_o, 16'h4501);
            chk("bp_s1_stall", stall_o, 1'b1);
            chk("bp_s1_bv", bundle_valid_o, 1'b0);
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            compressed_ready_i      = (c == 3);
            compressed_accept_i     = (c != 3);
            compressed_resp_instr_i = 32'hDEADBEEF;
            #1;
            chk("bp_s3_cvalid", compressed_valid_o, 1'b1);
            chk("bp_s3_cinstr", compressed_instr_o, 16'h8082);
            chk("bp_s3_stall", stall_o, 1'b1);
            tick();
        end
        compressed_ready_i = 1'b0;
        stall_i            = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("hold_bv", bundle_valid_o, 1'b1);
            chk("hold_stall", stall_o, 1'b1);
            chk("hold_instr", instruction_o,
                {32'h00008082, 32'hFFFFFFFF, 32'h00000513, 32'h00000013});
            chk("hold_comp", is_compressed_o, 4'b1000);
            chk("hold_ill", is_illegal_o, 4'b1100);
            chk("hold_cvalid", compressed_valid_o, 1'b0);
            tick();
        end
        stall_i = 1'b0;
        #1;
        chk("release_bv", bundle_valid_o, 1'b1);
        chk("release_stall", stall_o, 1'b0);
        tick();
        chk("release_idle_bv", bundle_valid_o, 1'b0);
        chk("release_idle_stall", stall_o, 1'b0);

        // Flush together with a handshake mid-OFFLOAD
        capture(4'b0011, 4'b0011, {32'h0, 32'h0, 32'h00004501, 32'h00009002});
        compressed_ready_i      = 1'b1;
        compressed_accept_i     = 1'b1;
        compressed_resp_instr_i = 32'h00100073;
        tick();
        bundle_valid_i = 1'b0;
        flush_i        = 1'b1;
        #1;
        chk("flush_c1_cvalid", compressed_valid_o, 1'b1);
        tick();
        flush_i = 1'b0;
        chk("flush_after_cvalid", compressed_valid_o, 1'b0);
        chk("flush_after_stall", stall_o, 1'b0);
        chk("flush_after_bv", bundle_valid_o, 1'b0);
        tick();
        chk("flush_stays_idle", compressed_valid_o, 1'b0);

        // Reset mid-OFFLOAD
        capture(4'b0011, 4'b0011, {32'h0, 32'h0, 32'h00004501, 32'h00009002});
        tick();
        bundle_valid_i = 1'b0;
        #1;
        chk("rmid_c1_cvalid", compressed_valid_o, 1'b1);
        rst_ni = 1'b0;
        tick();
        rst_ni          = 1'b1;
        is_compressed_i = 4'b0101;
        is_illegal_i    = 4'b0011;
        instruction_i   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        #1;
        chk("rmid_cvalid", compressed_valid_o, 1'b0);
        chk("rmid_bv", bundle_valid_o, 1'b0);
        chk("rmid_stall", stall_o, 1'b0);
        chk("rmid_instr", instruction_o, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        chk("rmid_comp", is_compressed_o, 4'b0101);
        chk("rmid_ill", is_illegal_o, 4'b0011);
        tick();
        chk("rmid_stays_idle", compressed_valid_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cvxif_compressed_offload_seq.md
# cvxif_compressed_offload_seq

Sequential, parametrised compressed-instruction offload stage. It sits between instruction realign/decompress and ID in the CVA6 frontend. It captures a fetch bundle of `NrSlots` instructions, serialises every illegal compressed slot over the CV-X-IF compressed interface, one handshake per slot, and presents the patched bundle downstream. Slot count is generalised, and valid/ready back-pressure and flush are supported.

## Interface
Parameters:
- `NrSlots`, default 2: instructions per fetch bundle; 1 to 8.
- `HartIdWidth`, default 32: width of the hart ID.

Ports (the clock, `clk_i`, is the single clock; reset, `rst_ni`, is synchronous and active-low):
- `clk_i`  in  1  clock
- `rst_ni`  in  1  synchronous active-low reset
- `flush_i`  in  1  discard the captured bundle and any pending offload
- `hart_id_i`  in  HartIdWidth  hart ID placed in every request
- `bundle_valid_i`  in  1  input bundle valid
- `is_compressed_i`  in  NrSlots  per-slot compressed flag
- `is_illegal_i`  in  NrSlots  per-slot illegal flag
- `instruction_i`  in  NrSlots*32  slot i occupies bits [32i+31:32i]
- `stall_i`  in  1  downstream stall
- `bundle_valid_o`  out  1  output bundle valid
- `is_compressed_o`, `is_illegal_o`  out  NrSlots  patched per-slot flags
- `instruction_o`  out  NrSlots*32  patched instructions
- `stall_o`  out  1  stall to upstream
- `compressed_valid_o`  out  1  CV-X-IF compressed request valid
- `compressed_ready_i`  in  1  CV-X-IF compressed request ready
- `compressed_instr_o`  out  16  request instruction
- `compressed_hartid_o`  out  HartIdWidth  request hart ID
- `compressed_accept_i`  in  1  response: accepted
- `compressed_resp_instr_i`  in  32  response: expanded instruction

## Operation
- A slot is a candidate when `bundle_valid_i & is_illegal_i[i] & is_compressed_i[i]`. Illegal 32-bit slots are never offloaded.
- State machine: IDLE, OFFLOAD, PRESENT.
- **IDLE**
  - With no candidate, the input passes through combinationally: `bundle_valid_o=bundle_valid_i`, `stall_o=stall_i`.
  - With at least one candidate, and `flush_i=0`:
    - capture all slots and the candidate mask into `pending_q`;
    - drive `bundle_valid_o=0` and `stall_o=1`;
    - go to OFFLOAD.
- **OFFLOAD**
  - Drive `stall_o=1`, `bundle_valid_o=0`, `compressed_valid_o=1`.
  - `compressed_instr_o` is bits [15:0] of the lowest-index pending slot.
  - On a handshake (`valid & ready`):
    - if `compressed_accept_i=1`, the slot instruction takes `compressed_resp_instr_i`, and both its `is_compressed` and `is_illegal` are cleared;
    - otherwise the slot is unchanged and stays illegal;
    - the slot's pending bit is cleared in both cases.
  - When the last pending bit clears, go to PRESENT.
  - The response is sampled in the handshake cycle only.
- **PRESENT**
  - Drive the registered bundle with `bundle_valid_o=1` and `stall_o=stall_i`. Inputs are ignored.
  - If `stall_i=0`, the bundle is consumed and the FSM goes to IDLE.
  - If `stall_i=1`, the bundle is held unchanged.
- `compressed_hartid_o=hart_id_i` at all times.
- `flush_i` (any state) forces IDLE at the next edge and clears `pending_q`:
  - `compressed_valid_o` deasserts that edge;
  - a handshake in the flush cycle is not applied;
  - in IDLE, `flush_i` suppresses capture.
- Reset: state IDLE, `pending_q=0`, slot registers 0.
  - With `bundle_valid_i=0`, the reset-time outputs are `bundle_valid_o=0`, `compressed_valid_o=0`, `stall_o=stall_i`, and `is_*_o`/`instruction_o` equal to the inputs.
  - Reset mid-OFFLOAD drops the request with no handshake.

## Timing
- Pass-through bundle: 0-cycle combinational latency.
- Bundle with k candidates and `compressed_ready_i` held high: the bundle is visible at the input in cycle 0; requests go out in cycles 1..k; `bundle_valid_o` rises in cycle k+1. `stall_o` is high in cycles 0..k.
- `compressed_valid_o` stays high and `compressed_instr_o` stays stable until ready; there is no combinational path from `compressed_ready_i` to `compressed_valid_o`.
- Slots are served in ascending index order. A mix of accepted and rejected responses is allowed within one bundle.

## Structure
- Shared package (`cvxif_offload_pkg`):
  - state enum `offload_state_e` {IDLE, OFFLOAD, PRESENT};
  - slot struct {instr[31:0], is_compressed, is_illegal};
  - constant `MaxSlots=8`.
- Sub-module: the existing common-cells `lzc` (trailing-zero mode) selects the lowest pending slot from `pending_q`. Everything else lives in one module.

## Test plan
- Pass-through: NrSlots=2, no illegal slot, `instruction_i={32'h00A00093, 32'h00000013}`, `stall_i=0` -> outputs equal inputs the same cycle; `compressed_valid_o=0`, `stall_o=0`.
- Single offload: slot0 illegal compressed `16'h9002`, `ready=1`, `accept=1`, `resp=32'h00100073` -> request in cycle 1 with `instr=16'h9002`; in cycle 2, slot0 = `32'h00100073` and `is_illegal_o[0]=0`, `is_compressed_o[0]=0`.
- Serialisation with back-pressure: NrSlots=4, slots 1 and 3 are candidates, `ready` low 3 cycles per request -> the slot1 request is held stable for 4 cycles, then slot3; PRESENT follows the second handshake; `stall_o` stays high throughout.
- Rejection: slot0 candidate, `accept=0` -> output slot0 is unchanged, `is_illegal_o[0]=1`, `is_compressed_o[0]=1`.
- Downstream stall in PRESENT: `stall_i=1` for 5 cycles -> the bundle is held with `bundle_valid_o=1`; it returns to IDLE the cycle after `stall_i` falls.
- Flush/reset: `flush_i` asserted with a handshake mid-OFFLOAD -> no slot update, IDLE next cycle, `compressed_valid_o=0`; `rst_ni=0` mid-OFFLOAD -> all reset values are restored next cycle.
